// File: rtl/fpga_version_reader_if.sv
`default_nettype none
//============================================================================
// Module      : fpga_version_reader_if
// Description : AXI4-Lite read-channel bundle between fpga_version_reader
//               and the version register slave. Only the AR and R channels
//               exist because the reader never writes.
//                 master modport : drives ARVALID/ARADDR/ARPROT/RREADY
//                 slave  modport : drives ARREADY/RVALID/RRESP/RDATA
// Revision    : 1.0  initial release
//============================================================================
interface fpga_version_reader_if;

    // Read address channel
    logic        AxiReadAddrValid_ValOut;
    logic        AxiReadAddrReady_RdyIn;
    logic [15:0] AxiReadAddrAddress_AdrOut;
    logic [2:0]  AxiReadAddrProt_DatOut;

    // Read data channel
    logic        AxiReadDataValid_ValIn;
    logic        AxiReadDataReady_RdyOut;
    logic [1:0]  AxiReadDataResponse_DatIn;
    logic [31:0] AxiReadDataData_DatIn;

    modport master (
        output AxiReadAddrValid_ValOut,
        input  AxiReadAddrReady_RdyIn,
        output AxiReadAddrAddress_AdrOut,
        output AxiReadAddrProt_DatOut,
        input  AxiReadDataValid_ValIn,
        output AxiReadDataReady_RdyOut,
        input  AxiReadDataResponse_DatIn,
        input  AxiReadDataData_DatIn
    );

    modport slave (
        input  AxiReadAddrValid_ValOut,
        output AxiReadAddrReady_RdyIn,
        input  AxiReadAddrAddress_AdrOut,
        input  AxiReadAddrProt_DatOut,
        output AxiReadDataValid_ValIn,
        input  AxiReadDataReady_RdyOut,
        output AxiReadDataResponse_DatIn,
        output AxiReadDataData_DatIn
    );

endinterface : fpga_version_reader_if
`default_nettype wire

// File: rtl/fpga_version_reader.sv
`default_nettype none
//============================================================================
// Module      : fpga_version_reader
// Description : AXI4-Lite read-only master that fetches the 32-bit FPGA
//               version register after reset and/or on request, optionally
//               re-polls it, and holds the last good value on discrete
//               outputs for status logic.
//
// Ports
//   SysClk_ClkIn        in   system clock, rising edge
//   SysRst_RstIn        in   asynchronous active-high reset
//   Start_EvtIn         in   single-cycle request for one read
//   AxiRead             mst  AXI4-Lite AR/R channels (fpga_version_reader_if)
//   Version_DatOut      out  last successfully read register value
//   VersionValid_ValOut out  Version_DatOut holds a good value
//   Busy_ValOut         out  a read is in flight
//   RespError_ErrOut    out  last completed read returned RRESP != OKAY
//   Timeout_ErrOut      out  current or last read exceeded the timeout
//
// Revision    : 1.0  initial release
//============================================================================
module fpga_version_reader #(
    parameter logic [15:0] VersionRegAddr_Gen = 16'h0000,
    parameter bit          AutoStart_Gen      = 1'b1,
    parameter int unsigned PollPeriod_Gen     = 0,
    parameter int unsigned TimeoutCycles_Gen  = 1023
) (
    input  wire logic               SysClk_ClkIn,
    input  wire logic               SysRst_RstIn,
    input  wire logic               Start_EvtIn,
    fpga_version_reader_if.master   AxiRead,
    output logic [31:0]             Version_DatOut,
    output logic                    VersionValid_ValOut,
    output logic                    Busy_ValOut,
    output logic                    RespError_ErrOut,
    output logic                    Timeout_ErrOut
);

    //------------------------------------------------------------------------
    // Constants
    //------------------------------------------------------------------------
    // Poll counter must hold the value PollPeriod_Gen itself.
    localparam int unsigned c_POLL_W =
        (PollPeriod_Gen > 1) ? $clog2(PollPeriod_Gen + 1) : 1;
    localparam logic [c_POLL_W-1:0] c_POLL_END = c_POLL_W'(PollPeriod_Gen);
    localparam bit c_POLL_EN = (PollPeriod_Gen != 0);

    // Timeout limit is at most 2^20-1, so 20 bits always suffice.
    localparam int unsigned c_TO_W = 20;
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TimeoutCycles_Gen);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_arValid;
    logic                r_rReady;
    logic                r_busy;
    logic                r_autoPend;
    logic [c_POLL_W-1:0] r_pollCnt;
    logic [c_TO_W-1:0]   r_toCnt;
    logic                r_timeout;
    logic [31:0]         r_version;
    logic                r_versionValid;
    logic                r_respError;

    //------------------------------------------------------------------------
    // Combinational decode
    //------------------------------------------------------------------------
    logic                w_arHandshake;
    logic                w_rHandshake;
    logic                w_pollExpired;
    logic                w_launch;
    logic [c_TO_W-1:0]   w_toNext;

    assign w_arHandshake = r_arValid & AxiRead.AxiReadAddrReady_RdyIn;
    // RREADY is only high in DATA, so an early RVALID never completes a read.
    assign w_rHandshake  = r_rReady & AxiRead.AxiReadDataValid_ValIn;
    assign w_pollExpired = (r_state == c_ST_WAIT) && (r_pollCnt == c_POLL_END);

    // Every trigger source funnels into one launch strobe, so a Start that
    // coincides with the AutoStart cycle or with poll expiry yields exactly
    // one read. Start outside IDLE/WAIT is simply not looked at.
    always_comb begin
        w_launch = 1'b0;
        case (r_state)
            c_ST_IDLE: w_launch = Start_EvtIn | r_autoPend;
            c_ST_WAIT: w_launch = Start_EvtIn | w_pollExpired;
            default:   w_launch = 1'b0;
        endcase
    end

    assign w_toNext = r_toCnt + c_TO_W'(1);

    //------------------------------------------------------------------------
    // Handshake FSM
    //------------------------------------------------------------------------
    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_state    <= c_ST_IDLE;
            r_arValid  <= 1'b0;
            r_rReady   <= 1'b0;
            r_busy     <= 1'b0;
            r_autoPend <= AutoStart_Gen;
        end else begin
            // AutoStart only gets the very first cycle after reset release.
            r_autoPend <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_WAIT: begin
                    if (w_launch) begin
                        r_state   <= c_ST_ADDR;
                        r_arValid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                c_ST_ADDR: begin
                    // ARVALID is never withdrawn before ARREADY, even after
                    // the timeout flag has been raised.
                    if (w_arHandshake) begin
                        r_state   <= c_ST_DATA;
                        r_arValid <= 1'b0;
                        r_rReady  <= 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_rHandshake) begin
                        r_state  <= c_POLL_EN ? c_ST_WAIT : c_ST_IDLE;
                        r_rReady <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_arValid <= 1'b0;
                    r_rReady  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Poll interval counter: zero on entry to WAIT, counts once per WAIT
    // cycle and launches the next read when it has reached PollPeriod_Gen.
    //------------------------------------------------------------------------
    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_pollCnt <= '0;
        end else if ((r_state == c_ST_WAIT) && !w_launch) begin
            r_pollCnt <= r_pollCnt + c_POLL_W'(1);
        end else begin
            r_pollCnt <= '0;
        end
    end

    //------------------------------------------------------------------------
    // Timeout supervision. The count restarts with each launch and
    // saturates at the limit; the flag is sticky until the next launch so a
    // late completion still leaves the evidence visible.
    //------------------------------------------------------------------------
    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_toCnt   <= '0;
            r_timeout <= 1'b0;
        end else if (w_launch) begin
            r_toCnt   <= '0;
            r_timeout <= 1'b0;
        end else if (r_busy && (r_toCnt != c_TO_LIMIT)) begin
            r_toCnt <= w_toNext;
            if (w_toNext == c_TO_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Result capture. An error response keeps the previous good value on
    // the outputs and only raises the error flag.
    //------------------------------------------------------------------------
    always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
        if (SysRst_RstIn) begin
            r_version      <= '0;
            r_versionValid <= 1'b0;
            r_respError    <= 1'b0;
        end else if (w_rHandshake) begin
            if (AxiRead.AxiReadDataResponse_DatIn == 2'b00) begin
                r_version      <= AxiRead.AxiReadDataData_DatIn;
                r_versionValid <= 1'b1;
                r_respError    <= 1'b0;
            end else begin
                r_respError    <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign AxiRead.AxiReadAddrValid_ValOut   = r_arValid;
    assign AxiRead.AxiReadAddrAddress_AdrOut = VersionRegAddr_Gen;
    assign AxiRead.AxiReadAddrProt_DatOut    = 3'b000;
    assign AxiRead.AxiReadDataReady_RdyOut   = r_rReady;

    assign Version_DatOut      = r_version;
    assign VersionValid_ValOut = r_versionValid;
    assign Busy_ValOut         = r_busy;
    assign RespError_ErrOut    = r_respError;
    assign Timeout_ErrOut      = r_timeout;

endmodule : fpga_version_reader
`default_nettype wire

// File: tb/tb_fpga_version_reader.sv
`default_nettype none
//============================================================================
// Module      : tb_fpga_version_reader
// Description : Self-checking bench for fpga_version_reader. A scripted
//               slave answers each read after a chosen AR stall and R delay;
//               a transaction-level model predicts every output per cycle.
//               A second instance with polling enabled is watched by a
//               free-running monitor.
// Revision    : 1.0  initial release
//============================================================================
module tb_fpga_version_reader;

    localparam logic [15:0] c_ADDR = 16'h0040;
    localparam int          c_TO   = 8;
    localparam int          c_POLL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        startEv;
    logic        startPoll;

    logic [31:0] version,  pVersion;
    logic        vValid,   pValid;
    logic        busy,     pBusy;
    logic        respErr,  pRespErr;
    logic        toErr,    pToErr;

    logic [31:0] pollData;

    int checkCount = 0;
    int errorCount = 0;

    // Transaction-level model of the main instance's sticky outputs.
    logic [31:0] expVersion;
    logic        expValid;
    logic        expErr;
    logic        expTimeout;

    fpga_version_reader_if ifMain();
    fpga_version_reader_if ifPoll();

    always #5 clk = ~clk;

    fpga_version_reader #(
        .VersionRegAddr_Gen (c_ADDR),
        .AutoStart_Gen      (1'b1),
        .PollPeriod_Gen     (0),
        .TimeoutCycles_Gen  (c_TO)
    ) dut (
        .SysClk_ClkIn        (clk),
        .SysRst_RstIn        (rst),
        .Start_EvtIn         (startEv),
        .AxiRead             (ifMain),
        .Version_DatOut      (version),
        .VersionValid_ValOut (vValid),
        .Busy_ValOut         (busy),
        .RespError_ErrOut    (respErr),
        .Timeout_ErrOut      (toErr)
    );

    fpga_version_reader #(
        .VersionRegAddr_Gen (16'h0000),
        .AutoStart_Gen      (1'b1),
        .PollPeriod_Gen     (c_POLL),
        .TimeoutCycles_Gen  (1023)
    ) dutPoll (
        .SysClk_ClkIn        (clk),
        .SysRst_RstIn        (rst),
        .Start_EvtIn         (startPoll),
        .AxiRead             (ifPoll),
        .Version_DatOut      (pVersion),
        .VersionValid_ValOut (pValid),
        .Busy_ValOut         (pBusy),
        .RespError_ErrOut    (pRespErr),
        .Timeout_ErrOut      (pToErr)
    );

    // Zero-wait slave for the polling instance: the value it returns
    // increments after every completed read.
    assign ifPoll.AxiReadAddrReady_RdyIn    = 1'b1;
    assign ifPoll.AxiReadDataValid_ValIn    = 1'b1;
    assign ifPoll.AxiReadDataResponse_DatIn = 2'b00;
    assign ifPoll.AxiReadDataData_DatIn     = pollData;

    always @(posedge clk or posedge rst) begin
        if (rst)
            pollData <= 32'h0000_0100;
        else if (ifPoll.AxiReadDataReady_RdyOut)
            pollData <= pollData + 32'd1;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic driveJunk();
        ifMain.AxiReadAddrReady_RdyIn    = 1'($urandom_range(0, 1));
        ifMain.AxiReadDataValid_ValIn    = 1'($urandom_range(0, 1));
        ifMain.AxiReadDataResponse_DatIn = 2'($urandom_range(0, 3));
        ifMain.AxiReadDataData_DatIn     = $urandom;
    endtask

    task automatic checkIdle(input string tag);
        checkValue({tag, "_arvalid"}, 32'(ifMain.AxiReadAddrValid_ValOut), 32'd0);
        checkValue({tag, "_rready"},  32'(ifMain.AxiReadDataReady_RdyOut), 32'd0);
        checkValue({tag, "_busy"},    32'(busy), 32'd0);
        checkValue({tag, "_timeout"}, 32'(toErr), 32'(expTimeout));
        checkValue({tag, "_version"}, version, expVersion);
        checkValue({tag, "_valid"},   32'(vValid), 32'(expValid));
        checkValue({tag, "_resperr"}, 32'(respErr), 32'(expErr));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            startEv = 1'b0;
            driveJunk();
            @(negedge clk);
            checkIdle("idle");
        end
    endtask

    task automatic issueStart();
        @(posedge clk); #1;
        startEv = 1'b1;
        driveJunk();
    endtask

    // Called during the cycle that carries the trigger. The slave stalls
    // ARREADY for arDly cycles and raises RVALID rDly cycles into DATA, so
    // the read occupies arDly+rDly+2 busy cycles and results appear in the
    // cycle after. k counts cycles from ARVALID rising.
    task automatic runRead(input int arDly, input int rDly,
                           input logic [1:0] resp, input logic [31:0] data,
                           input bit stormStart);
        int len = arDly + rDly + 2;
        for (int k = 0; k <= len + 2; k++) begin
            @(posedge clk); #1;
            startEv = (stormStart && k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k < arDly)
                ifMain.AxiReadAddrReady_RdyIn = 1'b0;
            else if (k == arDly)
                ifMain.AxiReadAddrReady_RdyIn = 1'b1;
            else
                ifMain.AxiReadAddrReady_RdyIn = 1'($urandom_range(0, 1));
            if (k == len - 1) begin
                ifMain.AxiReadDataValid_ValIn    = 1'b1;
                ifMain.AxiReadDataResponse_DatIn = resp;
                ifMain.AxiReadDataData_DatIn     = data;
            end else if (k <= arDly || k >= len) begin
                ifMain.AxiReadDataValid_ValIn    = 1'($urandom_range(0, 1));
                ifMain.AxiReadDataResponse_DatIn = 2'($urandom_range(0, 3));
                ifMain.AxiReadDataData_DatIn     = $urandom;
            end else begin
                ifMain.AxiReadDataValid_ValIn    = 1'b0;
            end
            if (k == len) begin
                if (resp == 2'b00) begin
                    expVersion = data;
                    expValid   = 1'b1;
                    expErr     = 1'b0;
                end else begin
                    expErr     = 1'b1;
                end
            end
            expTimeout = (len >= c_TO) && (k >= c_TO);
            @(negedge clk);
            checkValue("arvalid", 32'(ifMain.AxiReadAddrValid_ValOut), 32'(k <= arDly));
            checkValue("rready",  32'(ifMain.AxiReadDataReady_RdyOut), 32'(k > arDly && k < len));
            checkValue("busy",    32'(busy), 32'(k < len));
            checkValue("timeout", 32'(toErr), 32'(expTimeout));
            checkValue("version", version, expVersion);
            checkValue("valid",   32'(vValid), 32'(expValid));
            checkValue("resperr", 32'(respErr), 32'(expErr));
            if (k <= arDly) begin
                checkValue("araddr", 32'(ifMain.AxiReadAddrAddress_AdrOut), 32'(c_ADDR));
                checkValue("arprot", 32'(ifMain.AxiReadAddrProt_DatOut), 32'd0);
            end
        end
        startEv = 1'b0;
    endtask

    // Polling instance monitor: reads must start every 3+PollPeriod cycles,
    // ARVALID must be a single-cycle pulse with a ready slave, and the value
    // of each read must be on the outputs three cycles after its ARVALID.
    int  pCyc = 0;
    int  pLastRise = 0;
    int  pReads = 0;
    logic pPrevArv = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            pCyc++;
            if (rst) begin
                pReads   = 0;
                pPrevArv = 1'b0;
            end else begin
                if (pReads > 0 && pCyc == pLastRise + 1)
                    checkValue("poll_arvalid_pulse", 32'(ifPoll.AxiReadAddrValid_ValOut), 32'd0);
                if (ifPoll.AxiReadAddrValid_ValOut && !pPrevArv) begin
                    if (pReads > 0)
                        checkValue("poll_period", 32'(pCyc - pLastRise), 32'(c_POLL + 3));
                    pLastRise = pCyc;
                    pReads++;
                end
                if (pReads > 0 && pCyc == pLastRise + 3) begin
                    checkValue("poll_version", pVersion, 32'h0000_0100 + 32'(pReads - 1));
                    checkValue("poll_valid", 32'(pValid), 32'd1);
                end
                pPrevArv = ifPoll.AxiReadAddrValid_ValOut;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int arDly, rDly;
        logic [1:0] resp;
        rst        = 1'b1;
        startEv    = 1'b0;
        startPoll  = 1'b0;
        expVersion = '0;
        expValid   = 1'b0;
        expErr     = 1'b0;
        expTimeout = 1'b0;
        ifMain.AxiReadAddrReady_RdyIn    = 1'b0;
        ifMain.AxiReadDataValid_ValIn    = 1'b0;
        ifMain.AxiReadDataResponse_DatIn = 2'b00;
        ifMain.AxiReadDataData_DatIn     = '0;

        repeat (2) @(negedge clk);
        checkIdle("reset");

        // AutoStart read right after reset release, zero-wait slave.
        @(posedge clk); #1;
        rst = 1'b0;
        runRead(0, 0, 2'b00, 32'h0001_0203, 1'b0);
        idleCycles(2);

        // ARREADY stalled 5 cycles with Start pulses during the read.
        issueStart();
        runRead(5, 1, 2'b00, 32'h1111_2222, 1'b1);
        idleCycles(1);

        // Good read, error read, then a good read that clears the error.
        issueStart();
        runRead(1, 0, 2'b00, 32'hA5A5_0001, 1'b0);
        issueStart();
        runRead(0, 2, 2'b10, 32'hDEAD_BEEF, 1'b0);
        idleCycles(1);
        issueStart();
        runRead(2, 1, 2'b00, 32'h0BAD_F00D, 1'b0);

        // RVALID withheld until cycle 20: timeout at cycle 8, late capture.
        issueStart();
        runRead(0, 19, 2'b00, 32'h55AA_55AA, 1'b0);
        idleCycles(3);
        issueStart();
        runRead(0, 0, 2'b00, 32'h1234_5678, 1'b0);

        // Randomized reads.
        for (int t = 0; t < 30; t++) begin
            idleCycles($urandom_range(0, 3));
            arDly = $urandom_range(0, 4);
            rDly  = $urandom_range(0, 10);
            resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            issueStart();
            runRead(arDly, rDly, resp, $urandom, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while in DATA.
        issueStart();
        @(posedge clk); #1;
        startEv = 1'b0;
        ifMain.AxiReadAddrReady_RdyIn = 1'b1;
        ifMain.AxiReadDataValid_ValIn = 1'b0;
        @(posedge clk); #1;
        ifMain.AxiReadAddrReady_RdyIn = 1'b0;
        @(posedge clk); #1;
        checkValue("pre_reset_rready", 32'(ifMain.AxiReadDataReady_RdyOut), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expVersion = '0;
        expValid   = 1'b0;
        expErr     = 1'b0;
        expTimeout = 1'b0;
        checkIdle("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        runRead(0, 0, 2'b00, 32'hCAFE_0001, 1'b0);
        idleCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_fpga_version_reader
`default_nettype wire
